// File: rtl/branch_predictor.sv
// branch_predictor: IF-stage next-PC predictor, direct-mapped BTB with a 2-bit saturating counter per entry.
//
// Optional feature macro: BP_STATS_EN (trained-update and mispredict counters).
//
// Ports:
//   clk            in   1   clock, all state on rising edge
//   rst_n          in   1   synchronous active-low reset
//   if_pc          in   32  PC being fetched (lookup key)
//   pred_jump      out  1   1 = predict taken
//   pred_addr      out  32  predicted next PC (target if taken, else if_pc+4)
//   upd_valid      in   1   EX resolved a control-transfer instruction this cycle
//   upd_pc         in   32  PC of that instruction
//   upd_uncond     in   1   1 = JAL/JALR, 0 = conditional branch
//   upd_taken      in   1   actual outcome
//   upd_target     in   32  actual target
//   upd_mispredict in   1   EX redirected for this instruction
//   stat_updates   out  32  trained-update count (zero without BP_STATS_EN)
//   stat_mispred   out  32  mispredict count (zero without BP_STATS_EN)
module branch_predictor #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_jump,
    output logic [31:0] pred_addr,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_uncond,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispred
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [29:0]      tgt_q   [ENTRIES];
    logic [1:0]       cnt_q   [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit, wr_en, tgt_en;
    logic [1:0]       u_cnt, cnt_d;

    assign l_idx = if_pc[IDX_W+1:2];
    assign l_tag = if_pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];

    assign l_hit     = valid_q[l_idx] && tag_q[l_idx] == l_tag;
    assign pred_jump = l_hit && cnt_q[l_idx][1];
    assign pred_addr = pred_jump ? {tgt_q[l_idx], 2'b00} : if_pc + 32'd4;

    assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
    assign u_cnt = cnt_q[u_idx];

    // A miss that was not taken leaves the table alone; every other resolved update writes the entry.
    assign wr_en  = upd_valid && (u_hit || upd_taken);
    assign tgt_en = wr_en && (upd_taken || upd_uncond);

    always_comb begin
        cnt_d = upd_uncond ? 2'b11 :
                !u_hit     ? 2'b10 :
                upd_taken  ? (u_cnt == 2'b11 ? 2'b11 : u_cnt + 2'b01) :
                             (u_cnt == 2'b00 ? 2'b00 : u_cnt - 2'b01);
    end

    // Tags and targets are only meaningful under valid, so reset clears valid and counters alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_INIT;
            end
        end else if (wr_en) begin
            valid_q[u_idx] <= 1'b1;
            tag_q[u_idx]   <= u_tag;
            cnt_q[u_idx]   <= cnt_d;
            if (tgt_en) tgt_q[u_idx] <= upd_target[31:2];
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] upd_cnt_q, mis_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else if (upd_valid) begin
            if (upd_cnt_q != 32'hFFFF_FFFF) upd_cnt_q <= upd_cnt_q + 32'd1;
            if (upd_mispredict && mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign stat_updates = upd_cnt_q;
    assign stat_mispred = mis_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_target[1:0]};
`else
    assign stat_updates = 32'h0;
    assign stat_mispred = 32'h0;

    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_target[1:0], upd_mispredict};
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed-vector scoreboard bench for branch_predictor.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_jump;
    logic [31:0] pred_addr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_uncond = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;
    logic [31:0] stat_updates, stat_mispred;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_jump(pred_jump), .pred_addr(pred_addr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_uncond(upd_uncond), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_updates(stat_updates), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        j;
        logic [31:0] a;
        logic [31:0] su;
        logic [31:0] sm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int n = 1;
    logic [31:0] eu = '0;
    logic [31:0] em = '0;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d %s actual=%h required=%h", id, nm, act, exp);
        end
    endtask

    // Monitor: the lookup is combinational, so the DUT presents a result every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.id, "pred_jump", {31'b0, pred_jump}, {31'b0, e.j});
            chk(e.id, "pred_addr", pred_addr, e.a);
            chk(e.id, "stat_updates", stat_updates, e.su);
            chk(e.id, "stat_mispred", stat_mispred, e.sm);
        end
    end

    task automatic step(input logic r, input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                        input logic unc, input logic tk, input logic [31:0] tgt, input logic mis,
                        input logic ej, input logic [31:0] ea);
        exp_t e;
        rst_n = r; if_pc = pc; upd_valid = uv; upd_pc = upc;
        upd_uncond = unc; upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
        e.id = n; e.j = ej; e.a = ea;
`ifdef BP_STATS_EN
        e.su = eu; e.sm = em;
`else
        e.su = 32'h0; e.sm = 32'h0;
`endif
        q.push_back(e);
        n++;
        @(posedge clk); #1;
        if (!r) begin
            eu = '0; em = '0;
        end else if (uv) begin
            if (eu != 32'hFFFF_FFFF) eu = eu + 1;
            if (mis && em != 32'hFFFF_FFFF) em = em + 1;
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic ej, input logic [31:0] ea);
        step(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, ej, ea);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input logic unc, input logic tk,
                       input logic [31:0] tgt, input logic mis, input logic ej, input logic [31:0] ea);
        step(1'b1, pc, 1'b1, upc, unc, tk, tgt, mis, ej, ea);
    endtask

    initial begin
        @(posedge clk); #1;
        step(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
        // train 0x100 taken to 0x80: lookup in the same cycle sees the old miss
        upd(32'h100, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 32'h104);
        look(32'h100, 1'b1, 32'h80);
        // walk the counter down to 00 and hold it there
        upd(32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
        upd(32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
        upd(32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
        // two taken updates required before predicting taken again
        upd(32'h100, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
        upd(32'h100, 32'h100, 1'b0, 1'b1, 32'h84, 1'b0, 1'b0, 32'h104);
        look(32'h100, 1'b1, 32'h84);
        // upd_valid low: other upd_* inputs ignored
        step(1'b1, 32'h100, 1'b0, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h84);
        // saturate at 11, then a single not-taken still predicts taken
        upd(32'h100, 32'h100, 1'b0, 1'b1, 32'h84, 1'b0, 1'b1, 32'h84);
        upd(32'h100, 32'h100, 1'b0, 1'b1, 32'h84, 1'b0, 1'b1, 32'h84);
        upd(32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h84);
        look(32'h100, 1'b1, 32'h84);
        // aliasing: 0x140 shares index 0 and evicts 0x100
        upd(32'h140, 32'h140, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h144);
        look(32'h100, 1'b0, 32'h104);
        look(32'h140, 1'b1, 32'h200);
        // 0x300 trained down to 00, then an unconditional update
        upd(32'h300, 32'h300, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h304);
        upd(32'h300, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        upd(32'h300, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h304);
        upd(32'h300, 32'h300, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h304);
        look(32'h300, 1'b1, 32'h10);
        // unconditional miss allocates at 11: one not-taken still predicts taken
        upd(32'h404, 32'h404, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h408);
        upd(32'h404, 32'h404, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000);
        look(32'h404, 1'b1, 32'h1000);
        // miss and not taken allocates nothing
        upd(32'h808, 32'h808, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h80C);
        look(32'h808, 1'b0, 32'h80C);
        // pc[1:0] ignored, and +4 wraps at the top of the address space
        look(32'h302, 1'b1, 32'h10);
        look(32'hFFFF_FFFC, 1'b0, 32'h0);
        // mid-stream reset: effective at the edge, then everything misses
        step(1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
        look(32'h300, 1'b0, 32'h304);
        look(32'h140, 1'b0, 32'h144);
        look(32'h404, 1'b0, 32'h408);
        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
